// File: rtl/hand_display_pkg.sv
// Card codes, segment patterns and the scoring value map shared by the hand_display block.
package hand_display_pkg;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_A     = 4'd1;
  localparam logic [3:0] CARD_T     = 4'd10;
  localparam logic [3:0] CARD_J     = 4'd11;
  localparam logic [3:0] CARD_Q     = 4'd12;
  localparam logic [3:0] CARD_K     = 4'd13;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_K     = 7'b0001001;

  function automatic logic [3:0] card_value(input logic [3:0] code);
    if ((code >= CARD_A) && (code <= 4'd9)) begin
      return code;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/hand_display_if.sv
// Card load/clear handshake and display/score outputs of one hand_display instance.
interface hand_display_if #(
  parameter int unsigned N_SLOTS = 3
);
  localparam int unsigned CW = $clog2(N_SLOTS + 1);

  logic                   load;
  logic [3:0]             card;
  logic                   clear;
  logic [7*N_SLOTS-1:0]   hex_out;
  logic [3:0]             score;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   err;

  modport master (
    output load, card, clear,
    input  hex_out, score, count, full, err
  );

  modport slave (
    input  load, card, clear,
    output hex_out, score, count, full, err
  );

endinterface

// File: rtl/hand_display_card_seg_enc.sv
// Combinational card code to active-low 7-segment encoder; invalid codes show blank.
module card_seg_enc
  import hand_display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      CARD_A:  o_seg = SEG_A;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      CARD_T:  o_seg = SEG_0;
      CARD_J:  o_seg = SEG_J;
      CARD_Q:  o_seg = SEG_Q;
      CARD_K:  o_seg = SEG_K;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hand_display.sv
// Card-hand slot register, 7-segment driver and pipelined baccarat score.
// Optional newest-card blinking is compiled in with CARD_BLINK_EN.
module hand_display
  import hand_display_pkg::*;
#(
  parameter int unsigned N_SLOTS   = 3,
  parameter int unsigned BLINK_DIV = 4
) (
  input logic           slow_clock,
  input logic           resetb,
  hand_display_if.slave bus
);

  localparam int unsigned CW = $clog2(N_SLOTS + 1);

  if ((N_SLOTS < 1) || (N_SLOTS > 8) || (BLINK_DIV < 2)) begin : g_bad_param
    $error("hand_display: parameter out of range");
  end

  logic [3:0]           r_slot [N_SLOTS];
  logic [CW-1:0]        r_count;
  logic [3:0]           r_score;
  logic [3:0]           r_pend_val;
  logic                 r_pend_vld;
  logic                 r_err;

  logic                 w_full;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_reject;
  logic [4:0]           w_sum;
  logic [N_SLOTS-1:0]   w_blank;
  logic [7*N_SLOTS-1:0] w_hex;

  assign w_full   = (r_count == CW'(N_SLOTS));
  assign w_valid  = (bus.card >= CARD_A) && (bus.card <= CARD_K);
  assign w_accept = bus.load && !bus.clear && !w_full && w_valid;
  assign w_reject = bus.load && !bus.clear && (w_full || !w_valid);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= CARD_EMPTY;
      r_count <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= CARD_EMPTY;
      r_count <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (r_count == CW'(i)) r_slot[i] <= bus.card;
      end
      r_count <= r_count + CW'(1);
    end
  end

  // Score runs one stage behind the slots; clear drops any pending value.
  always_comb begin
    w_sum = {1'b0, r_score} + {1'b0, r_pend_val};
    if (w_sum >= 5'd10) w_sum = w_sum - 5'd10;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_score    <= 4'd0;
      r_pend_val <= 4'd0;
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
    end else if (bus.clear) begin
      r_score    <= 4'd0;
      r_pend_val <= 4'd0;
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (r_pend_vld) r_score <= w_sum[3:0];
      r_pend_vld <= w_accept;
      if (w_accept) r_pend_val <= card_value(bus.card);
      r_err <= w_reject;
    end
  end

`ifdef CARD_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (bus.clear || w_accept) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  always_comb begin
    w_blank = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!r_phase && (r_count == CW'(i + 1))) w_blank[i] = 1'b1;
    end
  end
`else
  assign w_blank = '0;
`endif

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_seg
    logic [3:0] w_code;
    assign w_code = w_blank[gi] ? CARD_EMPTY : r_slot[gi];
    card_seg_enc u_enc (
      .i_code (w_code),
      .o_seg  (w_hex[7*gi +: 7])
    );
  end

  assign bus.hex_out = w_hex;
  assign bus.score   = r_score;
  assign bus.count   = r_count;
  assign bus.full    = w_full;
  assign bus.err     = r_err;

endmodule
